fmap_rd_stream: RTL

Read-side companion to the feature-map write/address controller. On a start command it walks a contiguous address window of the feature-map buffer RAM (1-cycle read latency) and streams the words to the PE array over a valid/ready interface. It absorbs RAM latency under back-pressure with a 2-entry output FIFO and sustains 1 beat/cycle when the sink is always ready.

---
 rtl/fmap_pkg.sv | 12 +
 rtl/fmap_rd_fifo.sv | 63 ++++++
 rtl/fmap_rd_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fmap_pkg.sv
// Shared FSM encoding and FIFO sizing for the feature-map read streamer.
package fmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fmap_rd_state_t;

    localparam int FMAP_RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/fmap_rd_fifo.sv
// Two-entry register FIFO holding RAM words (plus beat flags) in front of the stream port.
module fmap_rd_fifo
    import fmap_pkg::*;
#(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;

    // Entry 0 is always the head; it only changes on pop or on a push into an empty FIFO.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) e0_d = din;
                else               e1_d = din;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = din;
                end else begin
                    e0_d = e1_q;
                    e1_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
            assert (!(push && !pop && occ_q == 2'(FMAP_RD_FIFO_DEPTH)));
            assert (!(pop && occ_q == 2'd0));
        end
    end

    assign occ  = occ_q;
    assign head = e0_q;

endmodule

// File: rtl/fmap_rd_stream.sv
// Streams a contiguous feature-map RAM window to the PE array over valid/ready.
// Optional multi-pass streaming is enabled by defining FMAP_RD_REPEAT_EN.
module fmap_rd_stream
    import fmap_pkg::*;
#(
    parameter int RD_ADDR_DEPTH = 8,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [RD_ADDR_DEPTH-1:0] base_addr,
    input  logic [RD_ADDR_DEPTH-1:0] len_m1,
`ifdef FMAP_RD_REPEAT_EN
    input  logic [7:0]               repeat_m1,
    output logic                     pass_last,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     ram_rd_en,
    output logic [RD_ADDR_DEPTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_last,
    output fmap_rd_state_t           dbg_state
);

`ifdef FMAP_RD_REPEAT_EN
    localparam int FLAG_W = 2;
`else
    localparam int FLAG_W = 1;
`endif
    localparam int FW = DATA_WIDTH + FLAG_W;
    localparam int CW = RD_ADDR_DEPTH + 1;

    // Handshake: a beat transfers on a clock edge where m_valid && m_ready; while
    // m_valid is high and m_ready low, m_data/m_last stay frozen on the FIFO head.

    fmap_rd_state_t           state_q, state_d;
    logic [RD_ADDR_DEPTH-1:0] base_q, base_d, len_q, len_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     inflight_q, inflight_d;
    logic [FLAG_W-1:0]        flags_q, flags_d, issue_flags;
`ifdef FMAP_RD_REPEAT_EN
    logic [7:0]               rep_q, rep_d, pass_q, pass_d;
`endif
    logic                     pop, pass_end, final_pass;
    logic [1:0]               occ;
    logic [2:0]               occ_after;
    logic [FW-1:0]            fifo_head;

    always_comb begin
        m_valid     = (occ != 2'd0);
        pop         = m_valid & m_ready;
        occ_after   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        ram_rd_en   = (state_q == ISSUE) && (occ_after < 3'd2);
        ram_rd_addr = base_q + cnt_q[RD_ADDR_DEPTH-1:0];
        pass_end    = (cnt_q == {1'b0, len_q});
`ifdef FMAP_RD_REPEAT_EN
        final_pass  = (pass_q == rep_q);
        issue_flags = {pass_end, pass_end & final_pass};
`else
        final_pass  = 1'b1;
        issue_flags = pass_end;
`endif
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        inflight_d = ram_rd_en;
        flags_d    = ram_rd_en ? issue_flags : flags_q;
`ifdef FMAP_RD_REPEAT_EN
        rep_d      = rep_q;
        pass_d     = pass_q;
`endif
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len_m1;
                    cnt_d   = '0;
                    state_d = ISSUE;
`ifdef FMAP_RD_REPEAT_EN
                    rep_d   = repeat_m1;
                    pass_d  = 8'd0;
`endif
                end
            end
            ISSUE: begin
                if (ram_rd_en) begin
                    if (pass_end) begin
                        cnt_d = '0;
                        if (final_pass) state_d = DRAIN;
`ifdef FMAP_RD_REPEAT_EN
                        else pass_d = pass_q + 8'd1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                // The last read may still be in flight when DRAIN is entered.
                if (occ == 2'd0 && !inflight_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            flags_q    <= '0;
`ifdef FMAP_RD_REPEAT_EN
            rep_q      <= 8'd0;
            pass_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            flags_q    <= flags_d;
`ifdef FMAP_RD_REPEAT_EN
            rep_q      <= rep_d;
            pass_q     <= pass_d;
`endif
        end
    end

    fmap_rd_fifo #(.W(FW)) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (inflight_q),
        .din  ({flags_q, ram_rd_data}),
        .pop  (pop),
        .occ  (occ),
        .head (fifo_head)
    );

    assign busy      = (state_q != IDLE);
    assign m_data    = fifo_head[DATA_WIDTH-1:0];
    assign m_last    = m_valid & fifo_head[DATA_WIDTH];
`ifdef FMAP_RD_REPEAT_EN
    assign pass_last = m_valid & fifo_head[DATA_WIDTH+1];
`endif
    assign dbg_state = state_q;

endmodule
